// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the UART FIFO driver.
// Parity states exist only when UART_PARITY_EN is defined.
package uart_pkg;

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    // One extra pointer bit separates full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head.
// Latency: pushed word visible on head the cycle after the push edge.
// Backpressure: push dropped when full unless a pop frees the slot that cycle; pop ignored when empty.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
        end
    end

endmodule

// File: rtl/uart_fifo_driver.sv
// Full-duplex UART with TX/RX FIFOs; optional parity via UART_PARITY_EN.
// Latency: tx_wr to start bit 2 cycles; RX word pushed at mid stop bit.
// Backpressure: tx_wr dropped when tx_full; RX word dropped with rx_overrun when RX FIFO full.
module uart_fifo_driver
    import uart_pkg::*;
#(
    parameter int BIT_DURATION  = 104,
    parameter int NUM_DATA_BITS = 8,
    parameter int NUM_STOP_BITS = 1,
    parameter int PARITY_ODD    = 0,
    parameter int TX_FIFO_DEPTH = 8,
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     rx_in,
    output logic                     tx_out,
    input  logic                     tx_wr,
    input  logic [NUM_DATA_BITS-1:0] tx_data,
    output logic                     tx_full,
    output logic                     tx_busy,
    input  logic                     rx_rd,
    output logic [NUM_DATA_BITS-1:0] rx_data,
    output logic                     rx_valid,
    output logic                     rx_frame_err,
    output logic                     rx_overrun,
    output logic                     rx_parity_err
);
    localparam int CNT_W = $clog2(BIT_DURATION);
    localparam int IDX_W = $clog2(NUM_DATA_BITS + 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_DURATION - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_DURATION / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(NUM_DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(NUM_STOP_BITS - 1);

    // ---------------- TX ----------------
    tx_state_t                tx_state, tx_state_nxt;
    logic [CNT_W-1:0]         tx_cnt, tx_cnt_nxt;
    logic [IDX_W-1:0]         tx_idx, tx_idx_nxt;
    logic [NUM_DATA_BITS-1:0] tx_shift, tx_shift_nxt;
    logic [NUM_DATA_BITS-1:0] tx_head;
    logic                     tx_empty, tx_pop, tx_load, tx_bit, tx_active;
`ifdef UART_PARITY_EN
    logic                     tx_par, tx_par_nxt;
`endif

    uart_sync_fifo #(.WIDTH(NUM_DATA_BITS), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .sys_clk(sys_clk), .rst(rst), .push(tx_wr), .push_dat(tx_data), .pop(tx_pop),
        .full(tx_full), .empty(tx_empty), .head(tx_head)
    );

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_shift  <= '0;
            tx_out    <= IDLE_LEVEL;
            tx_active <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par    <= 1'b0;
`endif
        end else begin
            tx_state  <= tx_state_nxt;
            tx_cnt    <= tx_cnt_nxt;
            tx_idx    <= tx_idx_nxt;
            tx_shift  <= tx_shift_nxt;
            tx_out    <= tx_bit;
            tx_active <= (tx_state != TX_IDLE);
`ifdef UART_PARITY_EN
            tx_par    <= tx_par_nxt;
`endif
        end
    end

    // tx_out is registered from the state, so the line trails the FSM by one cycle.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_idx_nxt   = tx_idx;
        tx_shift_nxt = tx_shift;
        tx_pop       = 1'b0;
        tx_load      = 1'b0;
        tx_bit       = IDLE_LEVEL;
`ifdef UART_PARITY_EN
        tx_par_nxt   = tx_par;
`endif
        if (tx_state == TX_IDLE) begin
            tx_load = !tx_empty;
        end else if (tx_cnt != '0) begin
            tx_cnt_nxt = tx_cnt - CNT_W'(1);
        end else begin
            tx_cnt_nxt = BIT_LOAD;
            case (tx_state)
                TX_START: begin
                    tx_state_nxt = TX_DATA;
                    tx_idx_nxt   = '0;
                end
                TX_DATA: begin
                    tx_shift_nxt = tx_shift >> 1;
                    if (tx_idx == LAST_DATA) begin
                        tx_idx_nxt = '0;
`ifdef UART_PARITY_EN
                        tx_state_nxt = TX_PARITY;
`else
                        tx_state_nxt = TX_STOP;
`endif
                    end else begin
                        tx_idx_nxt = tx_idx + IDX_W'(1);
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: tx_state_nxt = TX_STOP;
`endif
                TX_STOP: begin
                    if (tx_idx == LAST_STOP) begin
                        tx_idx_nxt   = '0;
                        tx_state_nxt = TX_IDLE;
                        tx_load      = !tx_empty;
                    end else begin
                        tx_idx_nxt = tx_idx + IDX_W'(1);
                    end
                end
                default: tx_state_nxt = TX_IDLE;
            endcase
        end
        if (tx_load) begin
            tx_pop       = 1'b1;
            tx_shift_nxt = tx_head;
            tx_cnt_nxt   = BIT_LOAD;
            tx_state_nxt = TX_START;
`ifdef UART_PARITY_EN
            tx_par_nxt   = (^tx_head) ^ PARITY_ODD[0];
`endif
        end
        case (tx_state)
            TX_START: tx_bit = 1'b0;
            TX_DATA:  tx_bit = tx_shift[0];
`ifdef UART_PARITY_EN
            TX_PARITY: tx_bit = tx_par;
`endif
            default:  tx_bit = IDLE_LEVEL;
        endcase
    end

    assign tx_busy = tx_active || (tx_state != TX_IDLE) || !tx_empty;

    // ---------------- RX ----------------
    rx_state_t                rx_state, rx_state_nxt;
    logic [CNT_W-1:0]         rx_cnt, rx_cnt_nxt;
    logic [IDX_W-1:0]         rx_idx, rx_idx_nxt;
    logic [NUM_DATA_BITS-1:0] rx_shift, rx_shift_nxt;
    logic                     rx_s1, rx_s2, rx_prev;
    logic                     rx_full, rx_empty, rx_push;
    logic                     frame_err_s, overrun_s;
`ifdef UART_PARITY_EN
    logic                     rx_par, rx_par_nxt, parity_err_s, parity_err_q;
`endif

    uart_sync_fifo #(.WIDTH(NUM_DATA_BITS), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .sys_clk(sys_clk), .rst(rst), .push(rx_push), .push_dat(rx_shift), .pop(rx_rd),
        .full(rx_full), .empty(rx_empty), .head(rx_data)
    );

    assign rx_valid = !rx_empty;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rx_s1        <= IDLE_LEVEL;
            rx_s2        <= IDLE_LEVEL;
            rx_prev      <= IDLE_LEVEL;
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par       <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_s1        <= rx_in;
            rx_s2        <= rx_s1;
            rx_prev      <= rx_s2;
            rx_state     <= rx_state_nxt;
            rx_cnt       <= rx_cnt_nxt;
            rx_idx       <= rx_idx_nxt;
            rx_shift     <= rx_shift_nxt;
            rx_frame_err <= frame_err_s;
            rx_overrun   <= overrun_s;
`ifdef UART_PARITY_EN
            rx_par       <= rx_par_nxt;
            parity_err_q <= parity_err_s;
`endif
        end
    end

`ifdef UART_PARITY_EN
    assign rx_parity_err = parity_err_q;
`else
    assign rx_parity_err = 1'b0;
`endif

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_idx_nxt   = rx_idx;
        rx_shift_nxt = rx_shift;
        rx_push      = 1'b0;
        frame_err_s  = 1'b0;
        overrun_s    = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_nxt   = rx_par;
        parity_err_s = 1'b0;
`endif
        if (rx_state == RX_IDLE) begin
            if (rx_prev && !rx_s2) begin
                rx_state_nxt = RX_START;
                rx_cnt_nxt   = HALF_LOAD;
            end
        end else if (rx_cnt != '0) begin
            rx_cnt_nxt = rx_cnt - CNT_W'(1);
        end else begin
            rx_cnt_nxt = BIT_LOAD;
            case (rx_state)
                // A start bit that is high again at mid-bit was a glitch.
                RX_START: begin
                    rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
                    rx_idx_nxt   = '0;
                end
                RX_DATA: begin
                    rx_shift_nxt = {rx_s2, rx_shift[NUM_DATA_BITS-1:1]};
                    if (rx_idx == LAST_DATA) begin
`ifdef UART_PARITY_EN
                        rx_state_nxt = RX_PARITY;
`else
                        rx_state_nxt = RX_STOP;
`endif
                    end else begin
                        rx_idx_nxt = rx_idx + IDX_W'(1);
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    rx_par_nxt   = rx_s2;
                    rx_state_nxt = RX_STOP;
                end
`endif
                RX_STOP: begin
                    rx_state_nxt = RX_IDLE;
                    if (!rx_s2)
                        frame_err_s = 1'b1;
`ifdef UART_PARITY_EN
                    else if (((^rx_shift) ^ rx_par) != PARITY_ODD[0])
                        parity_err_s = 1'b1;
`endif
                    else if (rx_full && !rx_rd)
                        overrun_s = 1'b1;
                    else
                        rx_push = 1'b1;
                end
                default: rx_state_nxt = RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_driver.sv
// Randomised self-checking bench for uart_fifo_driver (12 data bits, 104 cycles/bit, RX depth 4).
// Expected line waveforms and received words come from a frame-level model and a word queue.
module tb_uart_fifo_driver;
    localparam int BD = 104;
    localparam int N  = 12;
    localparam logic PAR_ODD = 1'b1;
`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FB   = 2 + N + P;
    localparam int PUSH = 3 + BD / 2 + (1 + N + P) * BD;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          rx_in, rx_drv, loopback;
    logic          tx_out, tx_wr, tx_full, tx_busy, rx_rd, rx_valid;
    logic [N-1:0]  tx_data, rx_data;
    logic          rx_frame_err, rx_overrun, rx_parity_err;

    int n_chk = 0, n_fail = 0;
    int fe_seen = 0, ovr_seen = 0, pe_seen = 0;
    int exp_fe = 0, exp_ovr = 0, exp_pe = 0;
    logic [N-1:0] exp_q[$];

    always #5 sys_clk = ~sys_clk;
    assign rx_in = loopback ? tx_out : rx_drv;

    uart_fifo_driver #(
        .BIT_DURATION(BD), .NUM_DATA_BITS(N), .NUM_STOP_BITS(1), .PARITY_ODD(1),
        .TX_FIFO_DEPTH(8), .RX_FIFO_DEPTH(4)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .rx_in(rx_in), .tx_out(tx_out),
        .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_busy(tx_busy),
        .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .rx_parity_err(rx_parity_err)
    );

    always @(negedge sys_clk) begin
        if (rx_frame_err === 1'b1) fe_seen++;
        if (rx_overrun === 1'b1) ovr_seen++;
        if (rx_parity_err === 1'b1) pe_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic par_of(input logic [N-1:0] d);
        return (^d) ^ PAR_ODD;
    endfunction

    // Level on the line during bit slot b of a frame carrying d.
    function automatic logic line_bit(input logic [N-1:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= N) return d[b-1];
        if (P == 1 && b == N + 1) return par_of(d);
        return 1'b1;
    endfunction

    task automatic send_frame(input logic [N-1:0] d, input logic stop_bit, input logic flip_par);
        @(posedge sys_clk); #1;
        for (int b = 0; b < FB; b++) begin
            rx_drv = line_bit(d, b);
            if (P == 1 && b == N + 1) rx_drv = rx_drv ^ flip_par;
            if (b == FB - 1) rx_drv = stop_bit;
            repeat (BD) @(posedge sys_clk);
            #1;
        end
        rx_drv = 1'b1;
    endtask

    // Model side of a well-formed frame arriving with no concurrent read.
    task automatic model_good(input logic [N-1:0] d);
        if (exp_q.size() < 4) exp_q.push_back(d);
        else exp_ovr++;
    endtask

    task automatic read_word(input string tag);
        logic [N-1:0] e;
        @(negedge sys_clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk({tag, "_valid"}, rx_valid, 1);
        chk({tag, "_data"}, rx_data, e);
        rx_rd = 1'b1;
        @(negedge sys_clk);
        rx_rd = 1'b0;
    endtask

    initial begin
        logic [N-1:0] lw[3];
        logic [N-1:0] w;
        int errs[3];
        int t_tot;

        rst = 1'b1; rx_drv = 1'b1; loopback = 1'b0;
        tx_wr = 1'b0; tx_data = '0; rx_rd = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_tx_out", tx_out, 1);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_err", {rx_frame_err, rx_overrun, rx_parity_err}, 0);
        rst = 1'b0;

        // Fill TX FIFO (first word popped one edge after its push), start an RX frame, reset mid-frame.
        @(negedge sys_clk);
        tx_wr = 1'b1; tx_data = N'($urandom_range(0, 4095)); rx_drv = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge sys_clk); #1;
            if (i == 7) chk("tx_not_full", tx_full, 0);
            if (i == 8) chk("tx_full", tx_full, 1);
            tx_data = N'($urandom_range(0, 4095));
        end
        tx_wr = 1'b0;
        repeat (300) @(negedge sys_clk);
        rst = 1'b1; rx_drv = 1'b1;
        @(negedge sys_clk);
        chk("midrst_tx_out", tx_out, 1);
        chk("midrst_tx_busy", tx_busy, 0);
        chk("midrst_tx_full", tx_full, 0);
        chk("midrst_rx_valid", rx_valid, 0);
        rst = 1'b0;
        repeat (FB * BD * 2) @(negedge sys_clk);
        chk("postrst_tx_out", tx_out, 1);
        chk("postrst_rx_valid", rx_valid, 0);
        chk("postrst_err", fe_seen + ovr_seen + pe_seen, 0);

        // Loopback, three back-to-back writes; per-cycle line check.
        loopback = 1'b1;
        lw[0] = 12'h4ca; lw[1] = 12'h0b5; lw[2] = 12'he91;
        errs[0] = 0; errs[1] = 0; errs[2] = 0;
        t_tot = 3 * FB * BD;
        @(negedge sys_clk);
        tx_wr = 1'b1; tx_data = lw[0];
        @(posedge sys_clk); #1; tx_data = lw[1];
        @(posedge sys_clk); #1; tx_data = lw[2];
        chk("tx_start_lat1", tx_out, 1);
        @(posedge sys_clk); #1; tx_wr = 1'b0;
        for (int j = 0; j <= t_tot; j++) begin
            if (j > 0) begin
                @(posedge sys_clk); #1;
            end
            if (j < t_tot) begin
                if (tx_out !== line_bit(lw[j / (FB * BD)], (j % (FB * BD)) / BD))
                    errs[j / (FB * BD)]++;
            end
            if (j == t_tot - 1) chk("tx_busy_last_stop", tx_busy, 1);
            if (j == t_tot) begin
                chk("tx_busy_done", tx_busy, 0);
                chk("tx_idle_after", tx_out, 1);
            end
        end
        for (int f = 0; f < 3; f++) begin
            chk("tx_frame_bits", errs[f], 0);
            model_good(lw[f]);
        end
        for (int f = 0; f < 3; f++) read_word("loop_rd");
        loopback = 1'b0;

        // Stop bit forced low.
        send_frame(12'hf10, 1'b0, 1'b0);
        exp_fe++;
        repeat (20) @(negedge sys_clk);
        chk("frame_err_cnt", fe_seen, exp_fe);
        chk("frame_err_valid", rx_valid, 0);

        // Start-bit glitch, then a real frame proves RX returned to idle.
        @(posedge sys_clk); #1; rx_drv = 1'b0;
        repeat (26) @(posedge sys_clk);
        #1; rx_drv = 1'b1;
        repeat (FB * BD) @(negedge sys_clk);
        chk("glitch_valid", rx_valid, 0);
        chk("glitch_err", fe_seen + ovr_seen + pe_seen, exp_fe);
        w = N'($urandom_range(0, 4095));
        send_frame(w, 1'b1, 1'b0);
        model_good(w);
        read_word("post_glitch");

        // Overrun: five frames into a 4-deep FIFO.
        for (int f = 0; f < 5; f++) begin
            w = N'($urandom_range(0, 4095));
            send_frame(w, 1'b1, 1'b0);
            model_good(w);
            repeat (5) @(negedge sys_clk);
            chk("ovr_cnt", ovr_seen, exp_ovr);
        end
        // Sixth frame with a read landing on the push cycle.
        w = N'($urandom_range(0, 4095));
        fork
            send_frame(w, 1'b1, 1'b0);
            begin
                @(posedge sys_clk);
                repeat (PUSH - 1) @(posedge sys_clk);
                #1;
                chk("rd_at_push_data", rx_data, exp_q[0]);
                rx_rd = 1'b1;
                @(posedge sys_clk); #1;
                rx_rd = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        exp_q.push_back(w);
        repeat (5) @(negedge sys_clk);
        chk("ovr_cnt_rd_push", ovr_seen, exp_ovr);
        for (int f = 0; f < 4; f++) read_word("ovr_rd");
        chk("ovr_drained", rx_valid, 0);

`ifdef UART_PARITY_EN
        send_frame(12'h51d, 1'b1, 1'b0);
        model_good(12'h51d);
        read_word("par_good");
        send_frame(12'h51d, 1'b1, 1'b1);
        exp_pe++;
        repeat (5) @(negedge sys_clk);
        chk("par_err_valid", rx_valid, 0);
`endif
        chk("par_err_cnt", pe_seen, exp_pe);

        // Random words through loopback with random gaps.
        loopback = 1'b1;
        for (int f = 0; f < 4; f++) begin
            w = N'($urandom_range(0, 4095));
            @(negedge sys_clk); tx_wr = 1'b1; tx_data = w;
            @(negedge sys_clk); tx_wr = 1'b0;
            model_good(w);
            repeat ($urandom_range(0, 200)) @(negedge sys_clk);
        end
        repeat (4 * FB * BD + 50) @(negedge sys_clk);
        chk("rand_tx_busy", tx_busy, 0);
        for (int f = 0; f < 4; f++) read_word("rand_rd");
        chk("final_frame_err", fe_seen, exp_fe);
        chk("final_ovr", ovr_seen, exp_ovr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
